// File: rtl/uart_pkg.sv
// Shared UART definitions: parity modes, FSM state encoding, clog2 helper.
// Used by uart_tx_param and the baud generator.
package uart_pkg;

  localparam int PAR_NONE = 0;
  localparam int PAR_ODD  = 1;
  localparam int PAR_EVEN = 2;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_START  = 3'd1;
  localparam logic [2:0] ST_DATA   = 3'd2;
  localparam logic [2:0] ST_PARITY = 3'd3;
  localparam logic [2:0] ST_STOP   = 3'd4;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++)
      if ((1 << i) < v) r = i + 1;
    return r;
  endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-period timer: counts 0..CLKS_PER_BIT-1 while enabled, 0 otherwise.
// Ports: i_clk, i_rst_n, i_clear (reload 0), i_enable, o_bit_end (count==max).
module uart_baud_gen
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_bit_end
);

  localparam int W = clog2(CLKS_PER_BIT);
  localparam logic [W-1:0] MAX = W'(CLKS_PER_BIT - 1);

  logic [W-1:0] r_cnt;
  logic [W-1:0] w_cnt_nxt;
  logic         r_end;

  always_comb begin
    w_cnt_nxt = '0;
    if (i_clear)
      w_cnt_nxt = '0;
    else if (i_enable)
      w_cnt_nxt = (r_cnt == MAX) ? '0 : r_cnt + W'(1);
  end

  // Strobe is registered from the next count so it
  // lines up with the cycle where r_cnt == MAX.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt <= '0;
      r_end <= 1'b0;
    end else begin
      r_cnt <= w_cnt_nxt;
      r_end <= (w_cnt_nxt == MAX);
    end
  end

  assign o_bit_end = r_end;

endmodule

// File: rtl/uart_tx_param.sv
// Parametrised UART transmitter with valid/ready input, parity, 1/2 stop bits.
// Ports: CLOCK_50, Reset_N, Tx_Valid, Tx_Data, Tx_Ready, Serial_Data, Busy, Tx_Done.
module uart_tx_param
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434,
  parameter int DATA_WIDTH   = 8,
  parameter int PARITY_MODE  = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic                  CLOCK_50,
  input  logic                  Reset_N,
  input  logic                  Tx_Valid,
  input  logic [DATA_WIDTH-1:0] Tx_Data,
  output logic                  Tx_Ready,
  output logic                  Serial_Data,
  output logic                  Busy,
  output logic                  Tx_Done
);

  if (PARITY_MODE < PAR_NONE || PARITY_MODE > PAR_EVEN) begin : g_bad_par
    $error("uart_tx_param: illegal PARITY_MODE");
  end
  if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop
    $error("uart_tx_param: illegal STOP_BITS");
  end
  if (DATA_WIDTH < 5 || DATA_WIDTH > 9) begin : g_bad_dw
    $error("uart_tx_param: illegal DATA_WIDTH");
  end

  localparam logic [3:0] LAST_DATA = 4'(DATA_WIDTH - 1);
  localparam logic [3:0] LAST_STOP = 4'(STOP_BITS - 1);

  logic [2:0]            r_state;
  logic [DATA_WIDTH-1:0] r_shift;
  logic [3:0]            r_bitcnt;
  logic                  r_par;
  logic                  r_serial;
  logic                  r_busy;

  logic w_bit_end;
  logic w_last_stop;
  logic w_ready;
  logic w_xfer;
  logic w_par;

  assign w_last_stop = (r_state == ST_STOP) && (r_bitcnt == LAST_STOP);
  assign w_ready     = (r_state == ST_IDLE) || (w_last_stop && w_bit_end);
  assign w_xfer      = Tx_Valid && w_ready;
  assign w_par       = (PARITY_MODE == PAR_ODD) ? ~^Tx_Data : ^Tx_Data;

  uart_baud_gen #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .i_clk    (CLOCK_50),
    .i_rst_n  (Reset_N),
    .i_clear  (w_xfer),
    .i_enable (r_state != ST_IDLE),
    .o_bit_end(w_bit_end)
  );

  // Serial_Data is driven straight from r_serial, which is
  // loaded with the level of the bit about to start.
  always_ff @(posedge CLOCK_50 or negedge Reset_N) begin
    if (!Reset_N) begin
      r_state  <= ST_IDLE;
      r_shift  <= '0;
      r_bitcnt <= '0;
      r_par    <= 1'b0;
      r_serial <= 1'b1;
      r_busy   <= 1'b0;
    end else begin
      if (w_xfer) begin
        r_state  <= ST_START;
        r_shift  <= Tx_Data;
        r_par    <= w_par;
        r_serial <= 1'b0;
        r_busy   <= 1'b1;
      end else if (w_bit_end) begin
        case (r_state)
          ST_START: begin
            r_state  <= ST_DATA;
            r_bitcnt <= '0;
            r_serial <= r_shift[0];
          end
          ST_DATA: begin
            if (r_bitcnt == LAST_DATA) begin
              r_bitcnt <= '0;
              if (PARITY_MODE != PAR_NONE) begin
                r_state  <= ST_PARITY;
                r_serial <= r_par;
              end else begin
                r_state  <= ST_STOP;
                r_serial <= 1'b1;
              end
            end else begin
              r_bitcnt <= r_bitcnt + 4'd1;
              r_shift  <= r_shift >> 1;
              r_serial <= r_shift[1];
            end
          end
          ST_PARITY: begin
            r_state  <= ST_STOP;
            r_bitcnt <= '0;
            r_serial <= 1'b1;
          end
          ST_STOP: begin
            if (r_bitcnt == LAST_STOP) begin
              r_state  <= ST_IDLE;
              r_bitcnt <= '0;
              r_busy   <= 1'b0;
            end else begin
              r_bitcnt <= r_bitcnt + 4'd1;
            end
            r_serial <= 1'b1;
          end
          default: begin
            r_state  <= ST_IDLE;
            r_serial <= 1'b1;
            r_busy   <= 1'b0;
          end
        endcase
      end
    end
  end

  // Ready/Done are decoded from flops only (state, bit
  // counter, registered strobe), never from Tx_Valid.
  assign Tx_Ready    = w_ready;
  assign Tx_Done     = w_last_stop && w_bit_end;
  assign Serial_Data = r_serial;
  assign Busy        = r_busy;

endmodule

// File: tb/tb_uart_tx_param.sv
// Directed bench for uart_tx_param across four parameter sets
// (even/odd/no parity, 5-bit data with two stop bits), CLKS_PER_BIT=4.
module tb_uart_tx_param;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic       v   [4];
  logic [7:0] d   [3];
  logic [4:0] d5;
  logic       rdy [4];
  logic       ser [4];
  logic       bsy [4];
  logic       dn  [4];

  int n_chk = 0;
  int n_err = 0;

  uart_tx_param #(.CLKS_PER_BIT(4), .DATA_WIDTH(8),
                  .PARITY_MODE(2), .STOP_BITS(1)) u_a (
    .CLOCK_50(clk), .Reset_N(rst_n), .Tx_Valid(v[0]), .Tx_Data(d[0]),
    .Tx_Ready(rdy[0]), .Serial_Data(ser[0]), .Busy(bsy[0]), .Tx_Done(dn[0]));

  uart_tx_param #(.CLKS_PER_BIT(4), .DATA_WIDTH(8),
                  .PARITY_MODE(1), .STOP_BITS(1)) u_b (
    .CLOCK_50(clk), .Reset_N(rst_n), .Tx_Valid(v[1]), .Tx_Data(d[1]),
    .Tx_Ready(rdy[1]), .Serial_Data(ser[1]), .Busy(bsy[1]), .Tx_Done(dn[1]));

  uart_tx_param #(.CLKS_PER_BIT(4), .DATA_WIDTH(8),
                  .PARITY_MODE(0), .STOP_BITS(1)) u_c (
    .CLOCK_50(clk), .Reset_N(rst_n), .Tx_Valid(v[2]), .Tx_Data(d[2]),
    .Tx_Ready(rdy[2]), .Serial_Data(ser[2]), .Busy(bsy[2]), .Tx_Done(dn[2]));

  uart_tx_param #(.CLKS_PER_BIT(4), .DATA_WIDTH(5),
                  .PARITY_MODE(2), .STOP_BITS(2)) u_d (
    .CLOCK_50(clk), .Reset_N(rst_n), .Tx_Valid(v[3]), .Tx_Data(d5),
    .Tx_Ready(rdy[3]), .Serial_Data(ser[3]), .Busy(bsy[3]), .Tx_Done(dn[3]));

  task automatic chk(input string tag, input logic [15:0] obs,
                     input logic [15:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input int k, input logic vv, input logic [7:0] dd);
    v[k] = vv;
    if (k == 3) d5 = dd[4:0];
    else d[k] = dd;
  endtask

  task automatic idle_chk(input int k);
    chk($sformatf("idle_ser k%0d", k), 16'(ser[k]), 16'd1);
    chk($sformatf("idle_busy k%0d", k), 16'(bsy[k]), 16'd0);
    chk($sformatf("idle_ready k%0d", k), 16'(rdy[k]), 16'd1);
    chk($sformatf("idle_done k%0d", k), 16'(dn[k]), 16'd0);
  endtask

  // bits[i] is the expected line level of bit slot i (slot 0 = start).
  task automatic run_frame(input int k, input logic [15:0] bits,
                           input int nb, input int c0, input int c1);
    logic last;
    for (int c = c0; c < c1; c++) begin
      @(negedge clk);
      last = (c == nb * 4 - 1);
      chk($sformatf("ser k%0d c%0d", k, c), 16'(ser[k]), 16'(bits[c/4]));
      chk($sformatf("busy k%0d c%0d", k, c), 16'(bsy[k]), 16'd1);
      chk($sformatf("done k%0d c%0d", k, c), 16'(dn[k]), 16'(last));
      chk($sformatf("ready k%0d c%0d", k, c), 16'(rdy[k]), 16'(last));
    end
  endtask

  task automatic send(input int k, input logic [7:0] dd);
    @(negedge clk);
    chk($sformatf("pre_ready k%0d", k), 16'(rdy[k]), 16'd1);
    drive(k, 1'b1, dd);
    @(posedge clk);
    #1;
    drive(k, 1'b0, dd);
  endtask

  initial begin
    rst_n = 1'b0;
    for (int k = 0; k < 4; k++) drive(k, 1'b0, 8'h00);
    repeat (2) @(negedge clk);
    for (int k = 0; k < 4; k++) idle_chk(k);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    for (int k = 0; k < 4; k++) idle_chk(k);

    // even parity, 0xA5 -> parity 0, 44 clocks
    send(0, 8'hA5);
    run_frame(0, 16'({1'b1, 1'b0, 8'hA5, 1'b0}), 11, 0, 44);
    @(negedge clk); idle_chk(0);

    // odd parity: 0x07 -> 0, 0x03 -> 1
    send(1, 8'h07);
    run_frame(1, 16'({1'b1, 1'b0, 8'h07, 1'b0}), 11, 0, 44);
    @(negedge clk); idle_chk(1);
    send(1, 8'h03);
    run_frame(1, 16'({1'b1, 1'b1, 8'h03, 1'b0}), 11, 0, 44);
    @(negedge clk); idle_chk(1);

    // no parity, 40 clocks
    send(2, 8'h07);
    run_frame(2, 16'({1'b1, 8'h07, 1'b0}), 10, 0, 40);
    @(negedge clk); idle_chk(2);

    // 5 data bits, even parity 1, two stop bits, 36 clocks
    send(3, 8'h1F);
    run_frame(3, 16'({1'b1, 1'b1, 1'b1, 5'h1F, 1'b0}), 9, 0, 36);
    @(negedge clk); idle_chk(3);

    // back-to-back with Tx_Valid held high
    @(negedge clk);
    drive(0, 1'b1, 8'h55);
    @(posedge clk); #1;
    drive(0, 1'b1, 8'hAA);
    run_frame(0, 16'({1'b1, 1'b0, 8'h55, 1'b0}), 11, 0, 44);
    @(posedge clk); #1;
    drive(0, 1'b0, 8'hAA);
    run_frame(0, 16'({1'b1, 1'b0, 8'hAA, 1'b0}), 11, 0, 44);
    @(negedge clk); idle_chk(0);

    // mid-frame valid ignored until ready
    send(0, 8'h3C);
    run_frame(0, 16'({1'b1, 1'b0, 8'h3C, 1'b0}), 11, 0, 10);
    drive(0, 1'b1, 8'hFF);
    run_frame(0, 16'({1'b1, 1'b0, 8'h3C, 1'b0}), 11, 10, 44);
    @(posedge clk); #1;
    drive(0, 1'b0, 8'hFF);
    run_frame(0, 16'({1'b1, 1'b0, 8'hFF, 1'b0}), 11, 0, 44);
    @(negedge clk); idle_chk(0);

    // reset mid-frame, then a clean frame
    send(0, 8'h5A);
    run_frame(0, 16'({1'b1, 1'b0, 8'h5A, 1'b0}), 11, 0, 10);
    rst_n = 1'b0;
    #1;
    idle_chk(0);
    @(negedge clk);
    rst_n = 1'b1;
    send(0, 8'h01);
    run_frame(0, 16'({1'b1, 1'b1, 8'h01, 1'b0}), 11, 0, 44);
    @(negedge clk); idle_chk(0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
